// File: rtl/vrf_pkg.sv
// Shared definitions for the vector register file write path.
// Holds the register-file geometry, the element types used for register
// indices and vector data, the write-arbiter state encoding and a small
// helper for stepping a register index with wrap.
package vrf_pkg;

    localparam int NREGS  = 16;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 128;
    localparam int LEN_W  = 2;

    typedef logic [ADDR_W-1:0] vreg_idx_t;
    typedef logic [DATA_W-1:0] vec_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // NREGS is a power of two, so the natural overflow of the index
    // gives the modulo-NREGS wrap.
    function automatic vreg_idx_t vreg_inc(input vreg_idx_t idx);
        return idx + vreg_idx_t'(1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-one finder.
// Scans req upward starting at ptr, wrapping past N-1 back to 0, and
// reports the first asserted requester.
// Ports:
//   req    [N-1:0]  request vector
//   ptr    [IW-1:0] index where the scan starts (highest priority)
//   onehot [N-1:0]  one-hot winner, zero when nothing requests
//   idx    [IW-1:0] binary winner index, zero when nothing requests
//   any             at least one request present
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Priority scan from ptr with wrap; first hit wins.
    always_comb begin
        int            pos_s;
        logic [IW-1:0] pos_idx_s;
        onehot    = {N{1'b0}};
        idx       = {IW{1'b0}};
        any       = 1'b0;
        pos_s     = 0;
        pos_idx_s = {IW{1'b0}};
        for (int i = 0; i < N; i++) begin
            pos_s = int'(ptr) + i;
            if (pos_s >= N) begin
                pos_s = pos_s - N;
            end else begin
                pos_s = pos_s;
            end
            pos_idx_s = IW'(pos_s);
            if (!any && req[pos_idx_s]) begin
                any               = 1'b1;
                onehot[pos_idx_s] = 1'b1;
                idx               = pos_idx_s;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/vrf_write_arbiter.sv
// Round-robin arbiter and burst sequencer for the vector register file
// write port. One requester owns the port at a time; each BURST cycle is
// one beat that drives a one-hot register enable, the destination index
// and the owner's data. Every burst is followed by one IDLE cycle, which
// doubles as the arbitration cycle for the next grant.
// Ports:
//   clk       system clock, state updates on the rising edge
//   rst       asynchronous active-low reset
//   req       per-requester write request, held for the whole burst
//   req_addr  per-requester start register index (packed)
//   req_len   per-requester burst length minus one (packed)
//   req_data  per-requester current beat data (packed)
//   gnt       registered one-hot owner
//   ack       one-hot beat-accepted pulse
//   we        one-hot register enables
//   waddr     current destination index (zero outside BURST)
//   wdata     owner's beat data (zero when nothing is granted)
//   busy      high while in BURST
module vrf_write_arbiter
    import vrf_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*LEN_W-1:0]    req_len,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          ack,
    output logic [NREGS-1:0]         we,
    output logic [ADDR_W-1:0]        waddr,
    output logic [DATA_W-1:0]        wdata,
    output logic                     busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t       state_r, state_n_s;
    logic [NREQ-1:0]  gnt_r, gnt_n_s;
    logic [IDX_W-1:0] owner_r, owner_n_s;
    logic [IDX_W-1:0] rr_ptr_r, rr_ptr_n_s;
    vreg_idx_t        cur_addr_r, cur_addr_n_s;
    logic [LEN_W-1:0] cnt_r, cnt_n_s;

    logic [NREQ-1:0]  pick_onehot_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic             pick_any_s;
    logic             beat_valid_s;

    rr_pick #(
        .N  (NREQ),
        .IW (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (rr_ptr_r),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .any    (pick_any_s)
    );

    // A beat only counts while the owner still holds its request.
    assign beat_valid_s = (state_r == BURST) && req[owner_r];

    // Next-state logic: arbitration in IDLE, address/count stepping in BURST.
    always_comb begin
        state_n_s    = state_r;
        gnt_n_s      = gnt_r;
        owner_n_s    = owner_r;
        rr_ptr_n_s   = rr_ptr_r;
        cur_addr_n_s = cur_addr_r;
        cnt_n_s      = cnt_r;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    state_n_s    = BURST;
                    gnt_n_s      = pick_onehot_s;
                    owner_n_s    = pick_idx_s;
                    cur_addr_n_s = req_addr[pick_idx_s*ADDR_W +: ADDR_W];
                    cnt_n_s      = req_len[pick_idx_s*LEN_W +: LEN_W];
                end else begin
                    gnt_n_s = {NREQ{1'b0}};
                end
            end
            BURST: begin
                // Last beat or owner abort both release the port and move
                // the pointer past the owner so it cannot starve others.
                if (!beat_valid_s || (cnt_r == {LEN_W{1'b0}})) begin
                    state_n_s = IDLE;
                    gnt_n_s   = {NREQ{1'b0}};
                    if (owner_r == IDX_W'(NREQ - 1)) begin
                        rr_ptr_n_s = {IDX_W{1'b0}};
                    end else begin
                        rr_ptr_n_s = owner_r + IDX_W'(1);
                    end
                end else begin
                    cnt_n_s      = cnt_r - LEN_W'(1);
                    cur_addr_n_s = vreg_inc(cur_addr_r);
                end
            end
            default: begin
                state_n_s = IDLE;
                gnt_n_s   = {NREQ{1'b0}};
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            gnt_r      <= {NREQ{1'b0}};
            owner_r    <= {IDX_W{1'b0}};
            rr_ptr_r   <= {IDX_W{1'b0}};
            cur_addr_r <= {ADDR_W{1'b0}};
            cnt_r      <= {LEN_W{1'b0}};
        end else begin
            state_r    <= state_n_s;
            gnt_r      <= gnt_n_s;
            owner_r    <= owner_n_s;
            rr_ptr_r   <= rr_ptr_n_s;
            cur_addr_r <= cur_addr_n_s;
            cnt_r      <= cnt_n_s;
        end
    end

    // Beat outputs: enable decode, ack, address and data mux.
    always_comb begin
        we    = {NREGS{1'b0}};
        ack   = {NREQ{1'b0}};
        waddr = {ADDR_W{1'b0}};
        wdata = {DATA_W{1'b0}};
        if (beat_valid_s) begin
            we[cur_addr_r] = 1'b1;
            ack            = gnt_r;
        end else begin
            ack = {NREQ{1'b0}};
        end
        if (state_r == BURST) begin
            waddr = cur_addr_r;
            wdata = req_data[owner_r*DATA_W +: DATA_W];
        end else begin
            waddr = {ADDR_W{1'b0}};
        end
    end

    assign gnt  = gnt_r;
    assign busy = (state_r == BURST);

endmodule

// File: tb/tb_vrf_write_arbiter.sv
// Directed bench for vrf_write_arbiter. Inputs change 1 time unit after a
// rising edge and outputs are checked 1 unit later, well before the
// falling edge.
module tb_vrf_write_arbiter;
    import vrf_pkg::*;

    localparam int NREQ = 4;

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*LEN_W-1:0]  req_len;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        ack;
    logic [NREGS-1:0]       we;
    logic [ADDR_W-1:0]      waddr;
    logic [DATA_W-1:0]      wdata;
    logic                   busy;

    int n_checks;
    int n_fail;

    vrf_write_arbiter #(.NREQ(NREQ)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .req_len  (req_len),
        .req_data (req_data),
        .gnt      (gnt),
        .ack      (ack),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [1:0] l, input logic [127:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_len[i*LEN_W +: LEN_W]    = l;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_gnt"},  128'(gnt),  128'd0);
        chk({tag, "_we"},   128'(we),   128'd0);
        chk({tag, "_ack"},  128'(ack),  128'd0);
    endtask

    task automatic chk_beat(input string tag, input int own, input int addr, input logic [127:0] d);
        chk({tag, "_gnt"},   128'(gnt),   128'(4'b0001 << own));
        chk({tag, "_ack"},   128'(ack),   128'(4'b0001 << own));
        chk({tag, "_we"},    128'(we),    128'(17'd1 << addr));
        chk({tag, "_waddr"}, 128'(waddr), 128'(addr));
        chk({tag, "_wdata"}, wdata, d);
        chk({tag, "_busy"},  128'(busy),  128'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        req      = 4'b0000;
        req_addr = '0;
        req_len  = '0;
        req_data = '0;

        // Reset state
        tick();
        chk_idle("rst");
        chk("rst_waddr", 128'(waddr), 128'd0);
        chk("rst_wdata", wdata, 128'd0);

        // Single burst: req0, addr 3, 3 beats
        tick();
        rst = 1'b1;
        req = 4'b0001;
        set_req(0, 4'd3, 2'd2, 128'hA);
        #1;
        chk_idle("sb_arb");
        tick();
        chk_beat("sb_b0", 0, 3, 128'hA);
        tick();
        req_data[0*DATA_W +: DATA_W] = 128'hB;
        #1;
        chk_beat("sb_b1", 0, 4, 128'hB);
        tick();
        req_data[0*DATA_W +: DATA_W] = 128'hC;
        #1;
        chk_beat("sb_b2", 0, 5, 128'hC);

        // Wrap-around: req1, addr 15, 2 beats
        tick();
        req = 4'b0010;
        set_req(1, 4'd15, 2'd1, 128'hD);
        #1;
        chk_idle("sb_done");
        tick();
        chk_beat("wr_b0", 1, 15, 128'hD);
        tick();
        req_data[1*DATA_W +: DATA_W] = 128'hE;
        #1;
        chk_beat("wr_b1", 1, 0, 128'hE);

        // Abort: req2 4-beat burst dropped after 2 beats, req3 waiting
        tick();
        req = 4'b1100;
        set_req(2, 4'd5, 2'd3, 128'hF1);
        set_req(3, 4'd9, 2'd0, 128'h33);
        #1;
        chk_idle("ab_arb");
        tick();
        chk_beat("ab_b0", 2, 5, 128'hF1);
        tick();
        req_data[2*DATA_W +: DATA_W] = 128'hF2;
        #1;
        chk_beat("ab_b1", 2, 6, 128'hF2);
        tick();
        req = 4'b1000;
        #1;
        chk("ab_drop_we",   128'(we),   128'd0);
        chk("ab_drop_ack",  128'(ack),  128'd0);
        chk("ab_drop_busy", 128'(busy), 128'd1);
        tick();
        chk_idle("ab_idle");
        tick();
        chk_beat("ab_next3", 3, 9, 128'h33);

        // Round-robin fairness: all request, single-beat bursts
        tick();
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 4'(2 * i + 2), 2'd0, 128'h100 + 128'(i));
        end
        #1;
        chk_idle("rr_arb");
        for (int k = 0; k < NREQ; k++) begin
            tick();
            chk_beat("rr_beat", k, 2 * k + 2, 128'h100 + 128'(k));
            tick();
            chk_idle("rr_gap");
        end
        tick();
        chk_beat("rr_wrap0", 0, 2, 128'h100);

        // Reset mid-burst: req0 4-beat burst from reg 8
        tick();
        req = 4'b0001;
        set_req(0, 4'd8, 2'd3, 128'h55);
        #1;
        chk_idle("rm_arb");
        tick();
        chk_beat("rm_b0", 0, 8, 128'h55);
        #2;
        rst = 1'b0;
        #1;
        chk_idle("rm_async");
        chk("rm_async_waddr", 128'(waddr), 128'd0);
        chk("rm_async_wdata", wdata, 128'd0);
        tick();
        rst = 1'b1;
        req = 4'b0011;
        #1;
        chk_idle("rm_release");
        tick();
        chk_beat("rm_regrant", 0, 8, 128'h55);

        // Owner drops, then idle quiescence
        tick();
        req = 4'b0000;
        #1;
        chk("q_drop_we", 128'(we), 128'd0);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk_idle("quiet");
            chk("quiet_wdata", wdata, 128'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
